// File: rtl/crypto_stage_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crypto_stage_seq : burst sequencer driving a fixed-latency crypto pipeline
// Revision 1.0
// ---------------------------------------------------------------------------
module crypto_stage_seq #(
  parameter int PIPE_DEPTH = 3,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [1:0]       fsm_state,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [1:0]            mode;
  logic [LEN_W-1:0]      remaining;
  logic [PIPE_DEPTH-1:0] vld;
  logic [PIPE_DEPTH-1:0] lst;
  logic                  aborted_q;

  logic accept;
  logic issue;
  logic issue_last;
  logic cancel;
  logic have_words;

  assign have_words = (remaining != '0);
  assign issue_last = issue && (remaining == LEN_W'(1));

  assign out_valid  = vld[PIPE_DEPTH-1];
  assign out_last   = out_valid & lst[PIPE_DEPTH-1];
  assign fsm_state  = mode;
  assign aborted    = aborted_q;

  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    src_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    cancel    = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        accept    = cfg_valid;
        if (cfg_valid) begin
          state_nx = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // A zero count in RUN is unreachable; guard it so nothing is issued.
        src_ready = have_words;
        if (abort) begin
          cancel   = 1'b1;
          state_nx = IDLE;
        end else if (src_valid && have_words) begin
          issue = 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          cancel   = 1'b1;
          state_nx = IDLE;
        end else if (out_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= 2'd0;
      remaining <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= cancel;
      if (accept) begin
        mode      <= cfg_mode;
        remaining <= cfg_len;
      end else if (cancel) begin
        remaining <= '0;
      end else if (issue) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Valid/last tracker mirrors the datapath latency; a cancel flushes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      lst <= '0;
    end else if (cancel) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= issue;
      lst[0] <= issue_last;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crypto_stage_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_crypto_stage_seq : directed cycle-by-cycle check of crypto_stage_seq
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_crypto_stage_seq;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_len;
  logic       abort;
  logic       src_valid;
  logic       src_ready;
  logic [1:0] fsm_state;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_assert;
  int n_fail;

  crypto_stage_seq #(
    .PIPE_DEPTH (3),
    .LEN_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .fsm_state (fsm_state),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Output vector: {cfg_ready, src_ready, fsm_state[1:0], out_valid, out_last, busy, done, aborted}
  task automatic chk(input string tag,
                     input logic cr, input logic sr, input logic [1:0] fs,
                     input logic ov, input logic ol, input logic b,
                     input logic d, input logic a);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {cfg_ready, src_ready, fsm_state, out_valid, out_last, busy, done, aborted};
    exp = {cr, sr, fs, ov, ol, b, d, a};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag,
                     input logic cr, input logic sr, input logic [1:0] fs,
                     input logic ov, input logic ol, input logic b,
                     input logic d, input logic a);
    chk(tag, cr, sr, fs, ov, ol, b, d, a);
    tick();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_len   = 8'd0;
    abort     = 1'b0;
    src_valid = 1'b0;
    #2;
    cyc("rst_async", 1,0,2'd0,0,0,0,0,0);

    // Release reset and present a request in the same cycle: accepted on the next edge.
    rst = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_len = 8'd4; src_valid = 1'b1;
    cyc("t1_idle",   1,0,2'd0,0,0,0,0,0);
    cfg_valid = 1'b0;
    cyc("t1_run1",   0,1,2'd2,0,0,1,0,0);
    cyc("t1_run2",   0,1,2'd2,0,0,1,0,0);
    cyc("t1_run3",   0,1,2'd2,0,0,1,0,0);
    cyc("t1_run4",   0,1,2'd2,1,0,1,0,0);
    cyc("t1_drain5", 0,0,2'd2,1,0,1,0,0);
    cyc("t1_drain6", 0,0,2'd2,1,0,1,0,0);
    cyc("t1_drain7", 0,0,2'd2,1,1,1,0,0);
    cyc("t1_done",   0,0,2'd2,0,0,1,1,0);

    // Bubbled source: 1,0,1,0,1
    cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_len = 8'd3; src_valid = 1'b1;
    cyc("t2_idle",   1,0,2'd2,0,0,0,0,0);
    cfg_valid = 1'b0; src_valid = 1'b1;
    cyc("t2_run1",   0,1,2'd3,0,0,1,0,0);
    src_valid = 1'b0;
    cyc("t2_run2",   0,1,2'd3,0,0,1,0,0);
    src_valid = 1'b1;
    cyc("t2_run3",   0,1,2'd3,0,0,1,0,0);
    src_valid = 1'b0;
    cyc("t2_run4",   0,1,2'd3,1,0,1,0,0);
    src_valid = 1'b1;
    cyc("t2_run5",   0,1,2'd3,0,0,1,0,0);
    src_valid = 1'b0;
    cyc("t2_drain6", 0,0,2'd3,1,0,1,0,0);
    cyc("t2_drain7", 0,0,2'd3,0,0,1,0,0);
    cyc("t2_drain8", 0,0,2'd3,1,1,1,0,0);
    cyc("t2_done",   0,0,2'd3,0,0,1,1,0);

    // Zero-length burst goes straight to DONE.
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_len = 8'd0; src_valid = 1'b1;
    cyc("t3_idle",   1,0,2'd3,0,0,0,0,0);
    cfg_valid = 1'b0;
    cyc("t3_done",   0,0,2'd1,0,0,1,1,0);

    // Abort after two issues; abort wins over a concurrent issue.
    cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_len = 8'd5; src_valid = 1'b1;
    cyc("t4_idle",   1,0,2'd1,0,0,0,0,0);
    cfg_valid = 1'b0;
    cyc("t4_run1",   0,1,2'd0,0,0,1,0,0);
    cyc("t4_run2",   0,1,2'd0,0,0,1,0,0);
    abort = 1'b1;
    cyc("t4_run3",   0,1,2'd0,0,0,1,0,0);
    abort = 1'b0;
    cyc("t4_abt",    1,0,2'd0,0,0,0,0,1);
    abort = 1'b1;
    cyc("t4_idle5",  1,0,2'd0,0,0,0,0,0);
    abort = 1'b0;
    cyc("t4_idle6",  1,0,2'd0,0,0,0,0,0);

    // Request with a new mode held through a running burst.
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_len = 8'd1; src_valid = 1'b1;
    cyc("t5_idle",   1,0,2'd0,0,0,0,0,0);
    cfg_mode = 2'd1; cfg_len = 8'd2;
    cyc("t5_run1",   0,1,2'd2,0,0,1,0,0);
    cyc("t5_drain2", 0,0,2'd2,0,0,1,0,0);
    cyc("t5_drain3", 0,0,2'd2,0,0,1,0,0);
    cyc("t5_drain4", 0,0,2'd2,1,1,1,0,0);
    cyc("t5_done",   0,0,2'd2,0,0,1,1,0);
    cyc("t5_accept", 1,0,2'd2,0,0,0,0,0);
    cfg_valid = 1'b0;
    cyc("t5_runb1",  0,1,2'd1,0,0,1,0,0);
    cyc("t5_runb2",  0,1,2'd1,0,0,1,0,0);

    // Reset in DRAIN with two words in flight.
    chk("t6_drain",  0,0,2'd1,0,0,1,0,0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst",    1,0,2'd0,0,0,0,0,0);
    tick();
    chk("t6_hold",   1,0,2'd0,0,0,0,0,0);
    rst = 1'b1; src_valid = 1'b0;
    tick();
    cyc("t6_post1",  1,0,2'd0,0,0,0,0,0);
    cyc("t6_post2",  1,0,2'd0,0,0,0,0,0);
    cyc("t6_post3",  1,0,2'd0,0,0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
